// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller: binary-to-BCD conversion,
// time-multiplexed digit drive, leading-zero blanking, decimal points and blink.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_HALF  = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] display_value,
    input  logic        load,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic        busy,
    output logic [7:0]  seg_data,
    output logic [3:0]  an
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = $clog2(BLINK_HALF + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [15:0]   MAX_SHOWN  = 16'd9999;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        UPDATE
    } conv_state_t;

    conv_state_t state, state_next;

    logic [15:0]   bin_sr;
    logic [15:0]   bcd_sr;
    logic [15:0]   bcd_adj;
    logic [3:0]    iter;
    logic [15:0]   digits;
    logic [15:0]   clamped;

    logic [PW-1:0] presc;
    logic          advance;
    logic [1:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic [3:0]    cur_digit;
    logic [3:0]    lz;
    logic          blanked;
    logic [6:0]    glyph;
    logic [7:0]    seg_next;
    logic [3:0]    an_next;

    // ---------------- Converter FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CONV;
            CONV:    if (iter == 4'd15) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign clamped = (display_value > MAX_SHOWN) ? MAX_SHOWN : display_value;

    // Add-3 correction on every BCD nibble before the shift.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_sr[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            iter   <= '0;
            digits <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sr <= clamped;
                        bcd_sr <= '0;
                        iter   <= '0;
                    end
                end
                CONV: begin
                    bcd_sr <= {bcd_adj[14:0], bin_sr[15]};
                    bin_sr <= {bin_sr[14:0], 1'b0};
                    iter   <= iter + 4'd1;
                end
                UPDATE: begin
                    digits <= bcd_sr;
                end
                default: ;
            endcase
        end
    end

    // ---------------- Refresh prescaler and scan index ----------------
    assign advance = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            if (advance) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Blink counts scan advances and is parked at phase 0 while disabled.
    always_ff @(posedge clk) begin
        if (rst || !blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (advance) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // ---------------- Digit decode and output registers ----------------
    assign cur_digit = digits[{idx, 2'b00} +: 4];

    // lz[k]: digit k and every higher digit are zero.
    always_comb begin
        lz[3] = (digits[15:12] == 4'd0);
        lz[2] = lz[3] && (digits[11:8] == 4'd0);
        lz[1] = lz[2] && (digits[7:4] == 4'd0);
        lz[0] = lz[1] && (digits[3:0] == 4'd0);
    end

    assign blanked = blank_lz && (idx != 2'd0) && lz[idx];

    always_comb begin
        case (cur_digit)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = 7'h7F;
        endcase
    end

    always_comb begin
        seg_next = 8'hFF;
        an_next  = 4'b1111;
        if (!(blink_en && blink_phase)) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = {~dp_mask[idx], blanked ? 7'h7F : glyph};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_data <= 8'hFF;
            an       <= 4'b1111;
        end else begin
            seg_data <= seg_next;
            an       <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: arithmetic reference model compared every
// cycle, plus directed literal checks of scan order, blanking, clamp and blink.
module tb_seg_scan_ctrl;

    localparam int unsigned DIV = 4;
    localparam int unsigned BH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] display_value;
    logic        load;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic        blink_en;
    logic        busy;
    logic [7:0]  seg_data;
    logic [3:0]  an;

    int vec  = 0;
    int miss = 0;

    seg_scan_ctrl #(.REFRESH_DIV(DIV), .BLINK_HALF(BH)) dut (
        .clk           (clk),
        .rst           (rst),
        .display_value (display_value),
        .load          (load),
        .dp_mask       (dp_mask),
        .blank_lz      (blank_lz),
        .blink_en      (blink_en),
        .busy          (busy),
        .seg_data      (seg_data),
        .an            (an)
    );

    always #5 clk = ~clk;

    // ---------------- Reference model ----------------
    logic [7:0] pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int pow10 [4] = '{1, 10, 100, 1000};

    bit         check_en = 1'b0;
    int         m_val;      // value currently in the digit registers
    int         m_pend;     // value being converted
    int         m_age;      // 0 = idle, otherwise cycle number within the conversion
    int         m_k;        // clock edges since reset released
    int         m_adv;      // scan advances since blink was enabled
    logic [7:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_busy;

    always @(posedge clk) begin
        int i;
        int d;
        bit blk;
        if (rst) begin
            exp_seg  = 8'hFF;
            exp_an   = 4'b1111;
            m_val    = 0;
            m_pend   = 0;
            m_age    = 0;
            m_k      = 0;
            m_adv    = 0;
            check_en = 1'b1;
        end else begin
            i = (m_k / DIV) % 4;
            if (blink_en && ((m_adv / BH) % 2 == 1)) begin
                exp_seg = 8'hFF;
                exp_an  = 4'b1111;
            end else begin
                d       = (m_val / pow10[i]) % 10;
                blk     = blank_lz && (i > 0) && (m_val < pow10[i]);
                exp_an  = ~(4'b0001 << i);
                exp_seg = {~dp_mask[i], blk ? 7'h7F : pat[d][6:0]};
            end
            if (m_age == 0) begin
                if (load) begin
                    m_pend = (display_value > 16'd9999) ? 9999 : int'(display_value);
                    m_age  = 1;
                end
            end else if (m_age == 17) begin
                m_val = m_pend;
                m_age = 0;
            end else begin
                m_age++;
            end
            if (!blink_en) m_adv = 0;
            else if (m_k % DIV == DIV - 1) m_adv++;
            m_k++;
        end
        exp_busy = (m_age != 0);
    end

    always @(negedge clk) begin
        if (check_en) begin
            vec++;
            if (busy !== exp_busy) begin
                miss++;
                $display("FAIL model_busy t=%0t got=%b want=%b", $time, busy, exp_busy);
            end
            vec++;
            if (an !== exp_an) begin
                miss++;
                $display("FAIL model_an t=%0t got=%b want=%b", $time, an, exp_an);
            end
            vec++;
            if (seg_data !== exp_seg) begin
                miss++;
                $display("FAIL model_seg t=%0t an=%b got=%h want=%h", $time, an, seg_data, exp_seg);
            end
        end
    end

    // ---------------- Directed helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        vec++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic wait_an(input logic [3:0] p, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (an === p) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic slot(input string name, input logic [3:0] p, input logic [7:0] want);
        bit ok;
        wait_an(p, ok);
        chk({name, "_found"}, 16'(ok), 16'd1);
        chk(name, 16'(seg_data), 16'(want));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick(1);
        end
        chk("busy_timeout", 16'(busy), 16'd0);
    endtask

    task automatic load_value(input logic [15:0] v);
        display_value = v;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        wait_idle();
        tick(3);
    endtask

    initial begin
        int n;
        bit ok;
        rst = 1'b1; load = 1'b0; display_value = '0;
        dp_mask = '0; blank_lz = 1'b1; blink_en = 1'b0;

        // Reset values and first registered output.
        tick(2);
        chk("rst_seg", 16'(seg_data), 16'h00FF);
        chk("rst_an", 16'(an), 16'h000F);
        chk("rst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        tick(1);
        chk("first_an", 16'(an), 16'b1110);
        chk("first_seg", 16'(seg_data), 16'h00C0);

        // Value 24: busy length, scan order, blanking, slot length.
        display_value = 16'd24;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick(1);
        end
        chk("busy_cycles", 16'(n), 16'd17);
        tick(3);
        slot("v24_d0", 4'b1110, 8'h99);
        slot("v24_d1", 4'b1101, 8'hA4);
        slot("v24_d2", 4'b1011, 8'hFF);
        slot("v24_d3", 4'b0111, 8'hFF);
        wait_an(4'b1110, ok);
        n = 0;
        while (an === 4'b1110 && n < 20) begin
            n++;
            tick(1);
        end
        chk("slot_len", 16'(n), 16'd4);

        // Clamp and a load dropped while busy.
        display_value = 16'd12345;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(2);
        display_value = 16'd5;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        wait_idle();
        tick(3);
        slot("clamp_d0", 4'b1110, 8'h90);
        slot("clamp_d1", 4'b1101, 8'h90);
        slot("clamp_d2", 4'b1011, 8'h90);
        slot("clamp_d3", 4'b0111, 8'h90);

        // Zero with and without blanking, decimal point on digit 0.
        load_value(16'd0);
        slot("z_d0", 4'b1110, 8'hC0);
        slot("z_d1", 4'b1101, 8'hFF);
        slot("z_d3", 4'b0111, 8'hFF);
        blank_lz = 1'b0;
        tick(2);
        slot("znb_d1", 4'b1101, 8'hC0);
        slot("znb_d2", 4'b1011, 8'hC0);
        slot("znb_d3", 4'b0111, 8'hC0);
        dp_mask = 4'b0001;
        tick(2);
        slot("zdp_d0", 4'b1110, 8'h40);
        dp_mask = 4'b0000;
        blank_lz = 1'b1;

        // Embedded zero stays lit; decimal point on a middle digit.
        dp_mask = 4'b0100;
        load_value(16'd105);
        slot("v105_d0", 4'b1110, 8'h92);
        slot("v105_d1", 4'b1101, 8'hC0);
        slot("v105_d2", 4'b1011, 8'h79);
        slot("v105_d3", 4'b0111, 8'hFF);
        dp_mask = 4'b1000;
        tick(2);
        slot("v105_dp_blank", 4'b0111, 8'h7F);
        dp_mask = 4'b0000;

        load_value(16'd9999);
        load_value(16'd10000);
        load_value(16'd1234);
        blank_lz = 1'b0;
        dp_mask = 4'b1010;
        tick(20);
        blank_lz = 1'b1;
        dp_mask = 4'b0000;

        // Blink: 8 dark cycles, 8 lit cycles, immediate resume when disabled.
        blink_en = 1'b1;
        wait_an(4'b1111, ok);
        chk("blink_found", 16'(ok), 16'd1);
        n = 0;
        while (an === 4'b1111 && n < 20) begin
            n++;
            tick(1);
        end
        chk("blink_dark_len", 16'(n), 16'd8);
        n = 0;
        while (an !== 4'b1111 && n < 20) begin
            n++;
            tick(1);
        end
        chk("blink_lit_len", 16'(n), 16'd8);
        tick(2);
        chk("blink_dark_seg", 16'(seg_data), 16'h00FF);
        blink_en = 1'b0;
        tick(1);
        chk("blink_off_an", 16'(an == 4'b1111), 16'd0);
        tick(10);

        // Reset during conversion, then immediate new load.
        display_value = 16'd24;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("midrst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        display_value = 16'd7;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        chk("midrst_an", 16'(an), 16'b1110);
        chk("midrst_seg", 16'(seg_data), 16'h00C0);
        chk("midrst_reload", 16'(busy), 16'd1);
        wait_idle();
        tick(3);
        slot("after_rst_d0", 4'b1110, 8'hF8);
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
